// File: rtl/debounce_pulse.sv
// Debounces a raw button/switch input into a clean, clock-synchronous level plus
// one-cycle rise/fall pulses.
// Latency: STABLE_CYCLES+3 clk edges from a stable input change to level/pulse
// (2 sync + 1 detect + STABLE_CYCLES count).
// Backpressure: none; free-running conditioner, the input is sampled every cycle.
//
// Ports:
//   clk     system clock, all state on rising edge
//   rst     asynchronous active-low reset
//   btn_in  raw asynchronous button level (may bounce)
//   level   debounced, synchronised level
//   rise    one-cycle pulse on level 0->1
//   fall    one-cycle pulse on level 1->0
module debounce_pulse #(
  parameter int STABLE_CYCLES = 1000,
  parameter int CNT_WIDTH     = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic rise,
  output logic fall
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  // Terminal count: the wait state exits here, so cnt never wraps.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic                 sync_meta;
  logic                 sync;
  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 level_nxt;
  logic                 rise_nxt;
  logic                 fall_nxt;
  logic                 accept_high;
  logic                 accept_low;

  // Two-flop synchroniser; only sync is seen by the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= btn_in;
      sync      <= sync_meta;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE_LOW;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= level_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE_LOW: begin
        if (sync) begin
          state_nxt = WAIT_HIGH;
          cnt_nxt   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync) begin
          // Bounce: drop back without any pulse.
          state_nxt = IDLE_LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_HIGH;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      IDLE_HIGH: begin
        if (!sync) begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = '0;
        end
      end
      WAIT_LOW: begin
        if (sync) begin
          state_nxt = IDLE_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE_LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output logic: pulses are computed on the accepting transition and
  // registered, so each lands in the first cycle of the new idle state.
  always_comb begin
    accept_high = (state == WAIT_HIGH) && sync  && (cnt == CNT_LAST);
    accept_low  = (state == WAIT_LOW)  && !sync && (cnt == CNT_LAST);
    rise_nxt    = accept_high;
    fall_nxt    = accept_low;
    level_nxt   = level;
    if (accept_high) begin
      level_nxt = 1'b1;
    end else if (accept_low) begin
      level_nxt = 1'b0;
    end
  end

endmodule
